// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
// ---------------------------------------------------------------------------
// Burst sequencer placed in front of a single-port synchronous RAM. Upstream
// logic issues one command (direction, base address, length-1); the
// controller then walks the RAM address space one word per cycle. Write
// beats arrive through a valid/ready handshake. Read words come back as a
// valid-qualified stream with no backpressure.
//
// Ports
//   clk, rst_n            clock / asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (cmd_wr, cmd_addr, cmd_len)
//   wdata_valid/ready     write beat handshake (wdata)
//   rdata_valid, rdata    read stream (rdata is the RAM output, passed through)
//   busy, done            burst in progress / one-cycle completion pulse
//   ram_addr/din/wr/cs    RAM control pins; ram_dout is the RAM read port
// ---------------------------------------------------------------------------
module ram_burst_ctrl #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wr,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wdata_valid,
  output logic          wdata_ready,
  input  logic [DW-1:0] wdata,
  output logic          rdata_valid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr,
  output logic          ram_cs,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_READ  = 2'd2
  } state_t;

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          rdata_valid_q, rdata_valid_d;
  logic          done_q, done_d;

  // Asynchronous reset forces IDLE, which immediately deasserts ram_cs and
  // abandons any burst in flight without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    rdata_valid_d = 1'b0;
    done_d        = 1'b0;
    ram_cs        = 1'b0;
    ram_wr        = 1'b0;
    wdata_ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ptr_d   = cmd_addr;
          cnt_d   = cmd_len;
          state_d = cmd_wr ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        wdata_ready = 1'b1;
        // Without a beat this is a bubble: RAM deselected, counters hold.
        if (wdata_valid) begin
          ram_cs = 1'b1;
          ram_wr = 1'b1;
          ptr_d  = ptr_q + ONE;   // wraps modulo 2**AW
          cnt_d  = cnt_q - ONE;
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end

      S_READ: begin
        ram_cs        = 1'b1;
        // RAM output lands one cycle after the address, hence the register.
        rdata_valid_d = 1'b1;
        ptr_d         = ptr_q + ONE;
        cnt_d         = cnt_q - ONE;
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign ram_addr    = ptr_q;
  assign ram_din     = wdata;
  assign rdata       = ram_dout;
  assign rdata_valid = rdata_valid_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign cmd_ready   = !busy;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl with a behavioural 1024x8 RAM.
module tb_ram_burst_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk         = 1'b0;
  logic          rst_n       = 1'b0;
  logic          cmd_valid   = 1'b0;
  logic          cmd_ready;
  logic          cmd_wr      = 1'b0;
  logic [AW-1:0] cmd_addr    = '0;
  logic [AW-1:0] cmd_len     = '0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [DW-1:0] wdata       = '0;
  logic          rdata_valid;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wr;
  logic          ram_cs;
  logic [DW-1:0] ram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mem    [0:DEPTH-1];
  logic [DW-1:0] golden [0:DEPTH-1];
  logic [DW-1:0] wbuf   [0:DEPTH-1];

  always #5 clk = ~clk;

  ram_burst_ctrl #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .busy(busy), .done(done),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wr(ram_wr), .ram_cs(ram_cs),
    .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM: write on cs&wr, registered read on cs&!wr.
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_wr) mem[ram_addr] <= ram_din;
      else        ram_dout      <= mem[ram_addr];
    end
  end

  task automatic issue_cmd(input bit wr, input int addr, input int len, input bit no_wait);
    if (!no_wait) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = addr[AW-1:0];
    cmd_len   = len[AW-1:0];
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL cmd_ready at issue addr=%0d: got %b want 1", addr, cmd_ready);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Writes wbuf[0..len] starting at addr; optional bubble run and an
  // illegal command poke on a chosen beat.
  task automatic write_burst(input int addr, input int len, input int bub_after,
                             input int bub_cycles, input int poke_at);
    int i   = 0;
    int bub = bub_cycles;
    int ea;
    issue_cmd(1'b1, addr, len, 1'b0);
    while (i <= len) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (i == bub_after && bub > 0) begin
        wdata_valid = 1'b0;
        bub--;
        #1;
        n_checks++;
        if ({ram_cs, ram_wr, wdata_ready, busy} !== 4'b0011) begin
          n_fail++; $display("FAIL bubble before beat %0d: cs/wr/wready/busy got %b want 0011", i, {ram_cs, ram_wr, wdata_ready, busy});
        end
      end else begin
        wdata_valid = 1'b1;
        wdata       = wbuf[i];
        if (i == poke_at) begin
          cmd_valid = 1'b1;
          cmd_wr    = 1'b0;
          cmd_addr  = 10'd7;
          cmd_len   = 10'd3;
        end
        #1;
        ea = (addr + i) % DEPTH;
        n_checks++;
        if ({ram_cs, ram_wr} !== 2'b11) begin
          n_fail++; $display("FAIL write beat %0d cs/wr: got %b want 11", i, {ram_cs, ram_wr});
        end
        n_checks++;
        if (ram_addr !== ea[AW-1:0]) begin
          n_fail++; $display("FAIL write beat %0d addr: got %0d want %0d", i, ram_addr, ea);
        end
        n_checks++;
        if (ram_din !== wbuf[i] || done !== 1'b0) begin
          n_fail++; $display("FAIL write beat %0d din/done: got %h/%b want %h/0", i, ram_din, done, wbuf[i]);
        end
        if (i == poke_at) begin
          n_checks++;
          if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL cmd_ready mid-burst: got %b want 0", cmd_ready);
          end
        end
        golden[ea] = wbuf[i];
        i++;
      end
    end
    @(negedge clk);
    wdata_valid = 1'b0;
    cmd_valid   = 1'b0;
    #1;
    n_checks++;
    if ({done, busy, ram_cs, cmd_ready} !== 4'b1001) begin
      n_fail++; $display("FAIL write end addr=%0d: done/busy/cs/cready got %b want 1001", addr, {done, busy, ram_cs, cmd_ready});
    end
  endtask

  // Reads len+1 words from addr and compares against the scoreboard.
  task automatic read_burst(input int addr, input int len, input bit no_wait);
    int ea;
    logic exp_v;
    issue_cmd(1'b0, addr, len, no_wait);
    for (int k = 0; k <= len + 1; k++) begin
      @(negedge clk);
      #1;
      if (k <= len) begin
        ea = (addr + k) % DEPTH;
        n_checks++;
        if ({ram_cs, ram_wr} !== 2'b10 || ram_addr !== ea[AW-1:0]) begin
          n_fail++; $display("FAIL read issue %0d: cs/wr=%b addr=%0d want 10 addr=%0d", k, {ram_cs, ram_wr}, ram_addr, ea);
        end
      end
      exp_v = (k >= 1);
      n_checks++;
      if (rdata_valid !== exp_v) begin
        n_fail++; $display("FAIL rdata_valid cycle %0d: got %b want %b", k, rdata_valid, exp_v);
      end
      if (k >= 1) begin
        ea = (addr + k - 1) % DEPTH;
        n_checks++;
        if (rdata !== golden[ea]) begin
          n_fail++; $display("FAIL rdata addr %0d: got %h want %h", ea, rdata, golden[ea]);
        end
      end
      exp_v = (k == len + 1);
      n_checks++;
      if (done !== exp_v) begin
        n_fail++; $display("FAIL read done cycle %0d: got %b want %b", k, done, exp_v);
      end
    end
  endtask

  task automatic idle_tail(input string tag);
    @(negedge clk);
    #1;
    n_checks++;
    if ({done, rdata_valid, busy} !== 3'b000) begin
      n_fail++; $display("FAIL %s tail done/rvalid/busy: got %b want 000", tag, {done, rdata_valid, busy});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if ({busy, cmd_ready, wdata_ready, ram_cs, ram_wr, rdata_valid, done} !== 7'b0100000) begin
      n_fail++; $display("FAIL reset outputs: got %b want 0100000", {busy, cmd_ready, wdata_ready, ram_cs, ram_wr, rdata_valid, done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    wdata_valid = 1'b1;   // must be ignored while idle
    #1;
    n_checks++;
    if ({busy, cmd_ready, wdata_ready, ram_cs} !== 4'b0100) begin
      n_fail++; $display("FAIL idle wdata ignored: busy/cready/wready/cs got %b want 0100", {busy, cmd_ready, wdata_ready, ram_cs});
    end
    @(negedge clk);
    wdata_valid = 1'b0;
  endtask

  task automatic test_write_read_basic();
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    write_burst(0, 3, -1, 0, -1);
    idle_tail("write0");
    read_burst(0, 3, 1'b0);
    idle_tail("read0");
  endtask

  task automatic test_wrap_bubbles();
    wbuf[0] = 8'h5A; wbuf[1] = 8'hA5; wbuf[2] = 8'h3C; wbuf[3] = 8'hC3;
    write_burst(1022, 3, 2, 2, -1);
    idle_tail("wrapw");
    read_burst(1022, 3, 1'b0);
    idle_tail("wrapr");
  endtask

  task automatic test_back_to_back();
    wbuf[0] = 8'hC1; wbuf[1] = 8'hC2;
    write_burst(200, 1, -1, 0, -1);
    read_burst(200, 1, 1'b1);   // accepted in the done cycle
    read_burst(201, 0, 1'b1);   // accepted in the final rdata_valid cycle
    idle_tail("b2b");
  endtask

  task automatic test_full_burst();
    for (int i = 0; i < DEPTH; i++) wbuf[i] = 8'($random);
    write_burst(0, DEPTH - 1, -1, 0, 500);
    idle_tail("fullw");
    read_burst(0, DEPTH - 1, 1'b0);
    idle_tail("fullr");
  endtask

  task automatic test_reset_mid_write();
    int ea;
    issue_cmd(1'b1, 100, 4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      wdata_valid = 1'b1;
      wdata       = 8'hA1 + 8'(i);
      ea          = 100 + i;
      golden[ea]  = wdata;
    end
    @(negedge clk);
    wdata = ~golden[102];
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ram_cs, ram_wr, busy, wdata_ready, cmd_ready, done} !== 6'b000010) begin
      n_fail++; $display("FAIL async reset mid-write cs/wr/busy/wready/cready/done: got %b want 000010", {ram_cs, ram_wr, busy, wdata_ready, cmd_ready, done});
    end
    cmd_valid = 1'b1;
    cmd_wr    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      ea    = 103 + i;
      wdata = ~golden[ea];
      #1;
      n_checks++;
      if (ram_cs !== 1'b0) begin
        n_fail++; $display("FAIL ram_cs held in reset cycle %0d: got %b want 0", i, ram_cs);
      end
    end
    @(negedge clk);
    rst_n       = 1'b1;
    cmd_valid   = 1'b0;
    wdata_valid = 1'b0;
    for (int i = 0; i < 3; i++) idle_tail("rstmid");
    read_burst(100, 4, 1'b0);
    idle_tail("rstread");
  endtask

  initial begin
    test_reset();
    test_write_read_basic();
    test_wrap_bubbles();
    test_back_to_back();
    test_full_burst();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
